// File: rtl/mem_stage_pkg.sv
// Shared configuration for the memory-access stage.
// Holds the datapath widths, the aluop codes for loads and stores,
// the alusel codes that mark an instruction as a load or a store,
// the access FSM state encoding and a helper that maps a load/store
// aluop to its transfer length in bytes.
package mem_stage_pkg;

   localparam int Reglen     = 32;
   localparam int RegAddrlen = 5;
   localparam int Addrlen    = 32;
   localparam int AluOPlen   = 8;
   localparam int AluSellen  = 3;

   localparam logic [AluOPlen-1:0] EXE_LB_OP  = 8'h20;
   localparam logic [AluOPlen-1:0] EXE_LH_OP  = 8'h21;
   localparam logic [AluOPlen-1:0] EXE_LW_OP  = 8'h22;
   localparam logic [AluOPlen-1:0] EXE_LBU_OP = 8'h23;
   localparam logic [AluOPlen-1:0] EXE_LHU_OP = 8'h24;
   localparam logic [AluOPlen-1:0] EXE_SB_OP  = 8'h28;
   localparam logic [AluOPlen-1:0] EXE_SH_OP  = 8'h29;
   localparam logic [AluOPlen-1:0] EXE_SW_OP  = 8'h2A;

   localparam logic [AluSellen-1:0] EXE_LOAD  = 3'b100;
   localparam logic [AluSellen-1:0] EXE_STORE = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Number of byte transfers an access needs.
   function automatic logic [2:0] byte_count(input logic [AluOPlen-1:0] op);
      logic [2:0] n;
      case (op)
         EXE_LW_OP, EXE_SW_OP:              n = 3'd4;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:  n = 3'd2;
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:  n = 3'd1;
         default:                           n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load result extension.
// Ports:
//   word   - little-endian word assembled from the byte transfers
//   aluop  - load operation code
//   result - sign/zero-extended load value (word unchanged for LW)
module mem_stage_load_ext
   import mem_stage_pkg::*;
#(
   parameter int DW  = Reglen,
   parameter int OPW = AluOPlen
) (
   input  logic [DW-1:0]  word,
   input  logic [OPW-1:0] aluop,
   output logic [DW-1:0]  result
);

   always_comb begin
      result = word;
      case (aluop)
         EXE_LB_OP:  result = {{(DW-8){word[7]}}, word[7:0]};
         EXE_LBU_OP: result = {{(DW-8){1'b0}}, word[7:0]};
         EXE_LH_OP:  result = {{(DW-16){word[15]}}, word[15:0]};
         EXE_LHU_OP: result = {{(DW-16){1'b0}}, word[15:0]};
         default:    result = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: turns loads/stores from EX/MEM into byte-serial
// transfers on the 8-bit memory-controller port and produces the MEM/WB
// write-back fields. Non-memory instructions pass straight through.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rdy               - global ready; low freezes all state
//   mem_*             - registered EX/MEM fields (data, rd, enable, op, addr)
//   wb_*              - write-back fields for MEM/WB (combinational)
//   stall_req         - holds pipeline stages while an access is in flight
//   mc_req/wr/addr/wdata, mc_rdata, mc_ack - memory-controller byte port
//   fsm_state         - current access state, for observation
//
// Controller handshake: mc_req, mc_wr, mc_addr and mc_wdata are registered
// and stay stable while mc_req is high until the controller pulses mc_ack;
// a byte completes on any clock edge where mc_req and mc_ack are both high
// (and rdy is high), with mc_rdata valid in that same cycle for reads.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DW   = Reglen,
   parameter int AW   = Addrlen,
   parameter int RAW  = RegAddrlen,
   parameter int OPW  = AluOPlen,
   parameter int SELW = AluSellen
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic [DW-1:0]   mem_rd_data,
   input  logic [RAW-1:0]  mem_rd_addr,
   input  logic            mem_rd_enable,
   input  logic [OPW-1:0]  mem_aluop,
   input  logic [SELW-1:0] mem_alusel,
   input  logic [AW-1:0]   mem_mem_addr,
   output logic [DW-1:0]   wb_rd_data,
   output logic [RAW-1:0]  wb_rd_addr,
   output logic            wb_rd_enable,
   output logic            stall_req,
   output logic            mc_req,
   output logic            mc_wr,
   output logic [AW-1:0]   mc_addr,
   output logic [7:0]      mc_wdata,
   input  logic [7:0]      mc_rdata,
   input  logic            mc_ack,
   output state_t          fsm_state
);

   state_t        state, state_next;
   logic [1:0]    k_q;
   logic [1:0]    k_next;
   logic [2:0]    n_q;
   logic [AW-1:0] base_q;
   logic [DW-1:0] sdata_q;
   logic [DW-1:0] data_q;
   logic [DW-1:0] ext_data;
   logic          is_load, is_store, mem_op, more;

   assign is_load  = (mem_alusel == EXE_LOAD);
   assign is_store = (mem_alusel == EXE_STORE);
   assign mem_op   = is_load || is_store;
   assign k_next   = k_q + 2'd1;
   // More bytes remain after the one completing now.
   assign more     = ({1'b0, k_q} + 3'd1) < n_q;

   assign fsm_state = state;

   // Low in DONE so EX/MEM advances past the finished instruction.
   assign stall_req = !rst && ((state == ST_IDLE && mem_op) || state == ST_ACCESS);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (rdy) begin
         unique case (state)
            ST_IDLE:   if (mem_op) state_next = ST_ACCESS;
            ST_ACCESS: if (mc_ack && !more) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q      <= '0;
         n_q      <= '0;
         base_q   <= '0;
         sdata_q  <= '0;
         data_q   <= '0;
         mc_req   <= 1'b0;
         mc_wr    <= 1'b0;
         mc_addr  <= '0;
         mc_wdata <= '0;
      end else if (rdy) begin
         unique case (state)
            ST_IDLE: begin
               if (mem_op) begin
                  n_q      <= byte_count(mem_aluop);
                  base_q   <= mem_mem_addr;
                  sdata_q  <= mem_rd_data;
                  data_q   <= '0;
                  k_q      <= '0;
                  mc_req   <= 1'b1;
                  mc_wr    <= is_store;
                  mc_addr  <= mem_mem_addr;
                  mc_wdata <= mem_rd_data[7:0];
               end
            end
            ST_ACCESS: begin
               if (mc_ack) begin
                  // mc_wr holds the latched direction of this access.
                  if (!mc_wr) data_q[8*k_q +: 8] <= mc_rdata;
                  k_q <= k_next;
                  if (more) begin
                     mc_addr  <= base_q + AW'(k_next);
                     mc_wdata <= sdata_q[8*k_next +: 8];
                  end else begin
                     mc_req <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   mem_stage_load_ext #(.DW(DW), .OPW(OPW)) u_load_ext (
      .word   (data_q),
      .aluop  (mem_aluop),
      .result (ext_data)
   );

   always_comb begin
      wb_rd_data   = mem_rd_data;
      wb_rd_addr   = mem_rd_addr;
      wb_rd_enable = mem_rd_enable;
      if (rst) begin
         wb_rd_data   = '0;
         wb_rd_addr   = '0;
         wb_rd_enable = 1'b0;
      end else if (is_load) begin
         wb_rd_data   = ext_data;
         wb_rd_enable = mem_rd_enable && (state == ST_DONE);
      end else if (is_store) begin
         wb_rd_enable = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model on the controller
// port, a transfer scoreboard and a load-result scoreboard.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam logic [2:0] SEL_NONE  = 3'b000;
   localparam logic [2:0] SEL_ARITH = 3'b001;
   localparam logic [7:0] OP_ADD    = 8'h01;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_enable;
   logic [7:0]  mem_aluop;
   logic [2:0]  mem_alusel;
   logic [31:0] mem_mem_addr;
   logic [31:0] wb_rd_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_enable;
   logic        stall_req;
   logic        mc_req;
   logic        mc_wr;
   logic [31:0] mc_addr;
   logic [7:0]  mc_wdata;
   logic [7:0]  mc_rdata;
   logic        mc_ack;
   state_t      fsm_state;

   logic [7:0]  mem [0:255];
   logic        ack_en = 1'b1;
   logic [63:0] ack_mask = '1;
   logic [63:0] rdy_mask = '1;

   // Expected transfers {wr, addr, wdata (0 for reads)} and load results.
   logic [40:0] xfer_q[$];
   logic [31:0] exp_q[$];
   logic [40:0] xe, xo;
   logic [31:0] re;

   // Per-cycle trace of the last run_op call.
   logic [31:0] tr_addr  [64];
   logic [7:0]  tr_wdata [64];
   logic        tr_req   [64];
   logic        tr_wben  [64];
   state_t      tr_state [64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign mc_ack   = mc_req & ack_en;
   assign mc_rdata = mem[mc_addr[7:0]];

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .mem_rd_data   (mem_rd_data),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_enable (mem_rd_enable),
      .mem_aluop     (mem_aluop),
      .mem_alusel    (mem_alusel),
      .mem_mem_addr  (mem_mem_addr),
      .wb_rd_data    (wb_rd_data),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_enable  (wb_rd_enable),
      .stall_req     (stall_req),
      .mc_req        (mc_req),
      .mc_wr         (mc_wr),
      .mc_addr       (mc_addr),
      .mc_wdata      (mc_wdata),
      .mc_rdata      (mc_rdata),
      .mc_ack        (mc_ack),
      .fsm_state     (fsm_state)
   );

   // Transfer scoreboard: a byte completes at the coming edge.
   always @(negedge clk) begin
      if (!rst && rdy && mc_req && mc_ack) begin
         n_checks++;
         xo = {mc_wr, mc_addr, (mc_wr ? mc_wdata : 8'h00)};
         if (xfer_q.size() == 0) begin
            n_fail++;
            $display("FAIL xfer_unexpected: got wr=%0b addr=%h wdata=%h, want no transfer",
                     mc_wr, mc_addr, mc_wdata);
         end else begin
            xe = xfer_q.pop_front();
            if (xo !== xe) begin
               n_fail++;
               $display("FAIL xfer: got wr=%0b addr=%h wdata=%h, want wr=%0b addr=%h wdata=%h",
                        xo[40], xo[39:8], xo[7:0], xe[40], xe[39:8], xe[7:0]);
            end
         end
         if (mc_wr) mem[mc_addr[7:0]] = mc_wdata;
      end
   end

   // Load-result scoreboard.
   always @(negedge clk) begin
      if (!rst && wb_rd_enable && mem_alusel == EXE_LOAD) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL load_unexpected: got wb_rd_data=%h, want no write-back", wb_rd_data);
         end else begin
            re = exp_q.pop_front();
            if (wb_rd_data !== re) begin
               n_fail++;
               $display("FAIL load_result: got %h, want %h", wb_rd_data, re);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_idle();
      mem_rd_data   = '0;
      mem_rd_addr   = '0;
      mem_rd_enable = 1'b0;
      mem_aluop     = '0;
      mem_alusel    = SEL_NONE;
      mem_mem_addr  = '0;
   endtask

   // Presents one memory op (starting edge+1) and runs it to completion,
   // recording a per-cycle trace; returns after the DONE edge.
   task automatic run_op(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] data,
                         output int stalls, output bit timeout);
      mem_aluop     = op;
      mem_alusel    = sel;
      mem_mem_addr  = addr;
      mem_rd_data   = data;
      mem_rd_addr   = 5'd10;
      mem_rd_enable = 1'b1;
      stalls  = 0;
      timeout = 1'b1;
      for (int c = 0; c < 64; c++) begin
         ack_en = ack_mask[c];
         rdy    = rdy_mask[c];
         #2;
         tr_addr[c]  = mc_addr;
         tr_wdata[c] = mc_wdata;
         tr_req[c]   = mc_req;
         tr_wben[c]  = wb_rd_enable;
         tr_state[c] = fsm_state;
         if (!stall_req) begin
            timeout = 1'b0;
            break;
         end
         stalls++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      set_idle();
      ack_en   = 1'b1;
      rdy      = 1'b1;
      ack_mask = '1;
      rdy_mask = '1;
   endtask

   task automatic test_reset();
      mem_aluop = EXE_LW_OP; mem_alusel = EXE_LOAD; mem_mem_addr = 32'h100;
      mem_rd_data = 32'h1111; mem_rd_addr = 5'd3; mem_rd_enable = 1'b1;
      #2;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, want 0", stall_req); end
      n_checks++; if (wb_rd_enable !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b, want 0", wb_rd_enable); end
      n_checks++; if (wb_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h, want 0", wb_rd_data); end
      n_checks++; if (wb_rd_addr !== 5'h0) begin n_fail++; $display("FAIL reset_wb_addr: got %h, want 0", wb_rd_addr); end
      n_checks++; if ({mc_req, mc_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_mc_ctl: got %b, want 00", {mc_req, mc_wr}); end
      n_checks++; if (mc_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mc_addr: got %h, want 0", mc_addr); end
      n_checks++; if (mc_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_mc_wdata: got %h, want 0", mc_wdata); end
      n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, want %0d", fsm_state, ST_IDLE); end
      @(posedge clk); #1;
      set_idle();
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      mem_aluop = OP_ADD; mem_alusel = SEL_ARITH; mem_mem_addr = 32'h44;
      mem_rd_data = 32'h1234; mem_rd_addr = 5'd5; mem_rd_enable = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_checks++; if (wb_rd_data !== 32'h1234) begin n_fail++; $display("FAIL pass_data: got %h, want 00001234", wb_rd_data); end
         n_checks++; if (wb_rd_addr !== 5'd5) begin n_fail++; $display("FAIL pass_addr: got %0d, want 5", wb_rd_addr); end
         n_checks++; if (wb_rd_enable !== 1'b1) begin n_fail++; $display("FAIL pass_en: got %b, want 1", wb_rd_enable); end
         n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %b, want 0", stall_req); end
         @(posedge clk); #1;
      end
      mem_rd_data = 32'hDEADBEEF; mem_rd_addr = 5'd31; mem_rd_enable = 1'b0;
      #2;
      n_checks++; if ({wb_rd_data, wb_rd_addr, wb_rd_enable} !== {32'hDEADBEEF, 5'd31, 1'b0}) begin
         n_fail++; $display("FAIL pass_pattern2: got %h/%0d/%b, want deadbeef/31/0", wb_rd_data, wb_rd_addr, wb_rd_enable);
      end
      n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL pass_state: got %0d, want %0d", fsm_state, ST_IDLE); end
      @(posedge clk); #1;
      set_idle();
   endtask

   task automatic test_lw();
      int stalls; bit to;
      for (int j = 0; j < 4; j++) xfer_q.push_back({1'b0, 32'(32'h100 + j), 8'h00});
      exp_q.push_back(32'h12345678);
      run_op(EXE_LW_OP, EXE_LOAD, 32'h100, 32'h0, stalls, to);
      n_checks++; if (to || stalls != 5) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d (timeout=%0b), want 5", stalls, to); end
      for (int c = 1; c <= 4; c++) begin
         n_checks++; if (tr_addr[c] !== 32'(32'h100 + c - 1) || tr_req[c] !== 1'b1) begin
            n_fail++; $display("FAIL lw_mc_addr[%0d]: got %h req=%b, want %h req=1", c, tr_addr[c], tr_req[c], 32'h100 + c - 1);
         end
      end
      for (int c = 0; c <= 4; c++) begin
         n_checks++; if (tr_wben[c] !== 1'b0) begin n_fail++; $display("FAIL lw_early_wb[%0d]: got %b, want 0", c, tr_wben[c]); end
      end
      n_checks++; if (tr_state[5] !== ST_DONE || tr_req[5] !== 1'b0) begin
         n_fail++; $display("FAIL lw_done: got state=%0d req=%b, want state=%0d req=0", tr_state[5], tr_req[5], ST_DONE);
      end
   endtask

   task automatic test_load_ext();
      logic [7:0]  ops  [4];
      logic [31:0] addrs[4];
      logic [31:0] exps [4];
      int          nb   [4];
      int stalls; bit to;
      ops   = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP};
      addrs = '{32'h7, 32'h7, 32'h40, 32'h40};
      exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
      nb    = '{1, 1, 2, 2};
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < nb[i]; j++) xfer_q.push_back({1'b0, 32'(addrs[i] + j), 8'h00});
         exp_q.push_back(exps[i]);
         run_op(ops[i], EXE_LOAD, addrs[i], 32'h0, stalls, to);
         n_checks++; if (to || stalls != nb[i] + 1) begin
            n_fail++; $display("FAIL ext_stall_cycles[%0d]: got %0d (timeout=%0b), want %0d", i, stalls, to, nb[i] + 1);
         end
      end
   endtask

   task automatic test_wrap();
      int stalls; bit to;
      xfer_q.push_back({1'b0, 32'hFFFFFFFF, 8'h00});
      xfer_q.push_back({1'b0, 32'h00000000, 8'h00});
      exp_q.push_back(32'h00007811);
      run_op(EXE_LH_OP, EXE_LOAD, 32'hFFFFFFFF, 32'h0, stalls, to);
      n_checks++; if (to || stalls != 3) begin n_fail++; $display("FAIL wrap_stall_cycles: got %0d, want 3", stalls); end
      n_checks++; if (tr_addr[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h, want 00000000", tr_addr[2]); end
   endtask

   task automatic test_store_ack_wait();
      int stalls; bit to;
      xfer_q.push_back({1'b1, 32'h20, 8'hDD});
      xfer_q.push_back({1'b1, 32'h21, 8'hCC});
      ack_mask[2] = 1'b0; ack_mask[3] = 1'b0; ack_mask[4] = 1'b0;
      run_op(EXE_SH_OP, EXE_STORE, 32'h20, 32'hAABBCCDD, stalls, to);
      n_checks++; if (to || stalls != 6) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d (timeout=%0b), want 6", stalls, to); end
      n_checks++; if (tr_state[6] !== ST_DONE) begin n_fail++; $display("FAIL sh_done: got %0d, want %0d", tr_state[6], ST_DONE); end
      n_checks++; if (tr_addr[1] !== 32'h20 || tr_wdata[1] !== 8'hDD) begin
         n_fail++; $display("FAIL sh_byte0: got %h/%h, want 00000020/dd", tr_addr[1], tr_wdata[1]);
      end
      for (int c = 2; c <= 4; c++) begin
         n_checks++; if (tr_addr[c] !== 32'h21 || tr_wdata[c] !== 8'hCC || tr_req[c] !== 1'b1) begin
            n_fail++; $display("FAIL sh_hold[%0d]: got %h/%h req=%b, want 00000021/cc req=1", c, tr_addr[c], tr_wdata[c], tr_req[c]);
         end
      end
      for (int c = 0; c <= 6; c++) begin
         n_checks++; if (tr_wben[c] !== 1'b0) begin n_fail++; $display("FAIL sh_wb_en[%0d]: got %b, want 0", c, tr_wben[c]); end
      end
      n_checks++; if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== {8'hDD, 8'hCC, 8'h00}) begin
         n_fail++; $display("FAIL sh_mem: got %h %h %h, want dd cc 00", mem[8'h20], mem[8'h21], mem[8'h22]);
      end
   endtask

   task automatic test_rdy_freeze();
      int stalls; bit to;
      for (int j = 0; j < 4; j++) xfer_q.push_back({1'b0, 32'(32'h100 + j), 8'h00});
      exp_q.push_back(32'h12345678);
      rdy_mask[2] = 1'b0; rdy_mask[3] = 1'b0;
      run_op(EXE_LW_OP, EXE_LOAD, 32'h100, 32'h0, stalls, to);
      n_checks++; if (to || stalls != 7) begin n_fail++; $display("FAIL rdy_stall_cycles: got %0d (timeout=%0b), want 7", stalls, to); end
      for (int c = 2; c <= 4; c++) begin
         n_checks++; if (tr_addr[c] !== 32'h101 || tr_req[c] !== 1'b1 || tr_state[c] !== ST_ACCESS) begin
            n_fail++; $display("FAIL rdy_freeze[%0d]: got %h req=%b state=%0d, want 00000101 req=1 state=%0d",
                               c, tr_addr[c], tr_req[c], tr_state[c], ST_ACCESS);
         end
      end
   endtask

   task automatic test_back_to_back();
      int stalls; bit to;
      xfer_q.push_back({1'b1, 32'h30, 8'h5A});
      run_op(EXE_SB_OP, EXE_STORE, 32'h30, 32'h1234565A, stalls, to);
      n_checks++; if (to || stalls != 2) begin n_fail++; $display("FAIL b2b_sb_stalls: got %0d, want 2", stalls); end
      xfer_q.push_back({1'b0, 32'h30, 8'h00});
      exp_q.push_back(32'h0000005A);
      run_op(EXE_LBU_OP, EXE_LOAD, 32'h30, 32'h0, stalls, to);
      n_checks++; if (to || stalls != 2) begin n_fail++; $display("FAIL b2b_lbu_stalls: got %0d, want 2", stalls); end
      n_checks++; if (tr_state[0] !== ST_IDLE || tr_req[1] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_start: got state=%0d req=%b, want state=%0d req=1", tr_state[0], tr_req[1], ST_IDLE);
      end
   endtask

   task automatic test_reset_abort();
      xfer_q.push_back({1'b0, 32'h80, 8'h00});
      xfer_q.push_back({1'b0, 32'h81, 8'h00});
      mem_aluop = EXE_LW_OP; mem_alusel = EXE_LOAD; mem_mem_addr = 32'h80;
      mem_rd_data = 32'h0; mem_rd_addr = 5'd9; mem_rd_enable = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #2;
      n_checks++; if (stall_req !== 1'b0 || wb_rd_enable !== 1'b0) begin
         n_fail++; $display("FAIL abort_in_reset: got stall=%b wb_en=%b, want 0/0", stall_req, wb_rd_enable);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      mem_aluop = OP_ADD; mem_alusel = SEL_ARITH; mem_mem_addr = 32'h0;
      mem_rd_data = 32'hCAFE; mem_rd_addr = 5'd7; mem_rd_enable = 1'b1;
      #2;
      n_checks++; if (mc_req !== 1'b0 || fsm_state !== ST_IDLE) begin
         n_fail++; $display("FAIL abort_idle: got req=%b state=%0d, want req=0 state=%0d", mc_req, fsm_state, ST_IDLE);
      end
      n_checks++; if ({wb_rd_data, wb_rd_addr, wb_rd_enable, stall_req} !== {32'hCAFE, 5'd7, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL abort_add: got %h/%0d/%b stall=%b, want 0000cafe/7/1 stall=0",
                            wb_rd_data, wb_rd_addr, wb_rd_enable, stall_req);
      end
      @(posedge clk); #1;
      n_checks++; if (mc_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_hold: got %b, want 0", mc_req); end
      set_idle();
      @(posedge clk); #1;
   endtask

   initial begin
      set_idle();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h78; mem[8'h01] = 8'h56; mem[8'h02] = 8'h34; mem[8'h03] = 8'h12;
      mem[8'h07] = 8'h80;
      mem[8'h40] = 8'h00; mem[8'h41] = 8'h80;
      mem[8'hFF] = 8'h11;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_passthrough();
      test_lw();
      test_load_ext();
      test_wrap();
      test_store_ack_wait();
      test_rdy_freeze();
      test_back_to_back();
      test_reset_abort();
      n_checks++; if (xfer_q.size() != 0) begin n_fail++; $display("FAIL xfer_left: got %0d pending, want 0", xfer_q.size()); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL load_left: got %0d pending, want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
